// File: rtl/pipelined_adder_if.sv
// Handshake bundle for pipelined_adder: operand side (in_*) and result side (out_*).
// master drives operations and consumes results; slave is the adder itself.
interface pipelined_adder_if #(
   parameter int N = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] i1;
   logic [N-1:0] i2;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] o1;
   logic         carry;
   logic         overflow;
   logic         zero;

   modport master (
      output in_valid, i1, i2, sub, out_ready,
      input  in_ready, out_valid, o1, carry, overflow, zero
   );

   modport slave (
      input  in_valid, i1, i2, sub, out_ready,
      output in_ready, out_valid, o1, carry, overflow, zero
   );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined N-bit adder/subtractor: one W-bit carry-chained slice per stage, skewed operands,
// global stall on output backpressure. Flags are formed in the last stage. Needs N % STAGES == 0.
module pipelined_adder #(
   parameter int N      = 16,
   parameter int STAGES = 4
) (
   input  logic               clk,
   input  logic               reset,
   pipelined_adder_if.slave   bus
);
   localparam int W = N / STAGES;

   logic [STAGES-1:0]          r_valid;
   logic [STAGES-1:0][N-1:0]   r_a;
   logic [STAGES-1:0][N-1:0]   r_b;
   logic [STAGES-1:0][N-1:0]   r_sum;
   logic [STAGES-1:0]          r_c;
   logic                       r_overflow;
   logic                       r_zero;

   logic                       w_adv;
   logic [STAGES-1:0][N-1:0]   w_a_src;
   logic [STAGES-1:0][N-1:0]   w_b_src;
   logic [STAGES-1:0][N-1:0]   w_sum_src;
   logic [STAGES-1:0]          w_c_src;
   logic [STAGES-1:0]          w_v_src;
   logic [STAGES-1:0][W:0]     w_slice;
   logic [STAGES-1:0][N-1:0]   w_sum_d;
   logic [STAGES-1:0]          w_c_d;
   logic                       w_overflow_d;
   logic                       w_zero_d;
   logic                       w_unused;

   always_comb begin
      w_adv = !r_valid[STAGES-1] || bus.out_ready;

      // Stage 0 sources come from the bus; subtract is i1 + ~i2 + 1.
      w_a_src[0]   = bus.i1;
      w_b_src[0]   = bus.sub ? ~bus.i2 : bus.i2;
      w_c_src[0]   = bus.sub;
      w_sum_src[0] = '0;
      w_v_src[0]   = bus.in_valid && w_adv;
      for (int k = 1; k < STAGES; k++) begin
         w_a_src[k]   = r_a[k-1];
         w_b_src[k]   = r_b[k-1];
         w_c_src[k]   = r_c[k-1];
         w_sum_src[k] = r_sum[k-1];
         w_v_src[k]   = r_valid[k-1];
      end

      for (int k = 0; k < STAGES; k++) begin
         w_slice[k] = {1'b0, w_a_src[k][k*W +: W]} + {1'b0, w_b_src[k][k*W +: W]}
                    + {{W{1'b0}}, w_c_src[k]};
         w_sum_d[k] = w_sum_src[k];
         w_sum_d[k][k*W +: W] = w_slice[k][W-1:0];
         w_c_d[k] = w_slice[k][W];
      end

      w_overflow_d = (w_a_src[STAGES-1][N-1] == w_b_src[STAGES-1][N-1])
                  && (w_sum_d[STAGES-1][N-1] != w_a_src[STAGES-1][N-1]);
      w_zero_d     = ~|w_sum_d[STAGES-1];
   end

   // Already-consumed operand slices in later stages are dead; fold them into one sink.
   assign w_unused = ^{r_a, r_b, w_a_src, w_b_src, w_sum_src};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid    <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_sum      <= '0;
         r_c        <= '0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
      end else if (w_adv) begin
         r_valid    <= w_v_src;
         r_a        <= w_a_src;
         r_b        <= w_b_src;
         r_sum      <= w_sum_d;
         r_c        <= w_c_d;
         r_overflow <= w_overflow_d;
         r_zero     <= w_zero_d;
      end
   end

   assign bus.in_ready  = w_adv;
   assign bus.out_valid = r_valid[STAGES-1];
   assign bus.o1        = r_sum[STAGES-1];
   assign bus.carry     = r_c[STAGES-1];
   assign bus.overflow  = r_overflow;
   assign bus.zero      = r_zero;
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (N=16, STAGES=4): latency, flags, backpressure and reset.
module tb_pipelined_adder;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;

   pipelined_adder_if #(.N(16)) u_if ();

   pipelined_adder #(
      .N      (16),
      .STAGES (4)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      n_checks++;
      if (obs !== expd) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expd);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation at full throughput and check latency and the presented result.
   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] exp_o, input logic exp_c,
                        input logic exp_v, input logic exp_z);
      u_if.i1        = a;
      u_if.i2        = b;
      u_if.sub       = s;
      u_if.in_valid  = 1'b1;
      u_if.out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, 32'(u_if.in_ready), 32'd1);
      next_cycle();
      u_if.in_valid = 1'b0;
      for (int e = 0; e < 3; e++) begin
         check({tag, "_early_valid"}, 32'(u_if.out_valid), 32'd0);
         next_cycle();
      end
      check({tag, "_out_valid"}, 32'(u_if.out_valid), 32'd1);
      check({tag, "_o1"},        32'(u_if.o1),        32'(exp_o));
      check({tag, "_carry"},     32'(u_if.carry),     32'(exp_c));
      check({tag, "_overflow"},  32'(u_if.overflow),  32'(exp_v));
      check({tag, "_zero"},      32'(u_if.zero),      32'(exp_z));
   endtask

   initial begin
      n_checks       = 0;
      n_fails        = 0;
      reset          = 1'b1;
      u_if.in_valid  = 1'b0;
      u_if.out_ready = 1'b1;
      u_if.i1        = '0;
      u_if.i2        = '0;
      u_if.sub       = 1'b0;

      #12;
      check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
      check("rst_o1",        32'(u_if.o1),        32'd0);
      check("rst_flags",     32'({u_if.carry, u_if.overflow, u_if.zero}), 32'd0);
      check("rst_in_ready",  32'(u_if.in_ready),  32'd1);
      #10;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         check("idle_no_valid", 32'(u_if.out_valid), 32'd0);
      end

      do_op("add",     16'h0020, 16'h0002, 1'b0, 16'h0022, 1'b0, 1'b0, 1'b0);
      do_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      do_op("sovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      do_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      do_op("sub_eq",  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

      // Hold a result on the output, then reset asynchronously mid-cycle.
      do_op("hold",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      u_if.out_ready = 1'b0;
      #3;
      check("hold_o1", 32'(u_if.o1), 32'h8000);
      reset = 1'b1;
      #1;
      check("arst_out_valid", 32'(u_if.out_valid), 32'd0);
      check("arst_o1",        32'(u_if.o1),        32'd0);
      check("arst_flags",     32'({u_if.carry, u_if.overflow, u_if.zero}), 32'd0);
      check("arst_in_ready",  32'(u_if.in_ready),  32'd1);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset          = 1'b0;
      u_if.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         check("arst_no_valid", 32'(u_if.out_valid), 32'd0);
      end

      // Backpressure: four back-to-back adds, then stall three cycles.
      for (int i = 1; i <= 4; i++) begin
         u_if.i1       = 16'(i);
         u_if.i2       = 16'(i);
         u_if.sub      = 1'b0;
         u_if.in_valid = 1'b1;
         #1;
         check("bp_accept", 32'(u_if.in_ready), 32'd1);
         next_cycle();
      end
      u_if.i1        = 16'h0F0F;
      u_if.i2        = 16'h0F0F;
      u_if.out_ready = 1'b0;
      #1;
      for (int j = 0; j < 3; j++) begin
         check("bp_in_ready", 32'(u_if.in_ready),  32'd0);
         check("bp_valid",    32'(u_if.out_valid), 32'd1);
         check("bp_o1_held",  32'(u_if.o1),        32'h0002);
         next_cycle();
      end
      check("bp_o1_after", 32'(u_if.o1), 32'h0002);
      u_if.in_valid  = 1'b0;
      u_if.out_ready = 1'b1;
      #1;
      check("bp_first", 32'(u_if.o1), 32'h0002);
      for (int i = 2; i <= 4; i++) begin
         next_cycle();
         check("bp_drain_valid", 32'(u_if.out_valid), 32'd1);
         check("bp_drain_o1",    32'(u_if.o1),        32'(2 * i));
      end
      next_cycle();
      check("bp_empty", 32'(u_if.out_valid), 32'd0);

      // Reset with two operations in flight: neither may ever appear.
      u_if.i1       = 16'h0100;
      u_if.i2       = 16'h0001;
      u_if.in_valid = 1'b1;
      next_cycle();
      u_if.i1       = 16'h0200;
      u_if.i2       = 16'h0002;
      next_cycle();
      u_if.in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("mrst_valid", 32'(u_if.out_valid), 32'd0);
      next_cycle();
      check("mrst_valid_hold", 32'(u_if.out_valid), 32'd0);
      #2;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         check("mrst_never", 32'(u_if.out_valid), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
